// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution over a raster-order image, no padding.
// Two line buffers feed a 3x3 window; one MAC stage produces each result.
module conv3x3_engine #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] kernel0,
  input  logic signed [7:0] kernel1,
  input  logic signed [7:0] kernel2,
  input  logic signed [7:0] kernel3,
  input  logic signed [7:0] kernel4,
  input  logic signed [7:0] kernel5,
  input  logic signed [7:0] kernel6,
  input  logic signed [7:0] kernel7,
  input  logic signed [7:0] kernel8,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_valid,
  output logic              busy,
  output logic signed [19:0] conv_out,
  output logic              conv_valid,
  output logic              done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic signed [7:0] k_q [9];
  logic signed [7:0] k_in [9];
  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] win_q [9];

  logic win_vld_q, win_last_q;
  logic conv_valid_q, done_q;
  logic signed [19:0] conv_out_q;
  logic signed [19:0] sum;

  logic accept, col_end, last_px, win_done;

  assign k_in = '{kernel0, kernel1, kernel2,
                  kernel3, kernel4, kernel5,
                  kernel6, kernel7, kernel8};

  assign accept   = (state_q == RUN) && pixel_valid;
  assign col_end  = col_q == CW'(IMG_W - 1);
  assign last_px  = col_end && (row_q == RW'(IMG_H - 1));
  assign win_done = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign busy       = state_q != IDLE;
  assign conv_out   = conv_out_q;
  assign conv_valid = conv_valid_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          col_d = col_end ? '0 : col_q + 1'b1;
          if (col_end) row_d = row_q + 1'b1;
          if (last_px) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel is zero-extended to 9b signed; each 17b product sign-extends into the sum.
  always_comb begin
    logic signed [16:0] px;
    logic signed [16:0] kw;
    logic signed [16:0] prod;
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      px   = 17'($signed({1'b0, win_q[i]}));
      kw   = 17'(k_q[i]);
      prod = px * kw;
      sum  = sum + 20'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      k_q          <= '{default: '0};
      win_q        <= '{default: '0};
      win_vld_q    <= 1'b0;
      win_last_q   <= 1'b0;
      conv_valid_q <= 1'b0;
      done_q       <= 1'b0;
      conv_out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (state_q == IDLE && start) k_q <= k_in;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r*3]   <= win_q[r*3+1];
          win_q[r*3+1] <= win_q[r*3+2];
        end
        win_q[2] <= lb1_q[col_q];
        win_q[5] <= lb0_q[col_q];
        win_q[8] <= pixel_in;
      end
      win_vld_q    <= accept && win_done;
      win_last_q   <= accept && last_px;
      conv_valid_q <= win_vld_q;
      done_q       <= win_vld_q && win_last_q;
      if (win_vld_q) conv_out_q <= sum;
    end
  end

  // Line buffers hold no reset; only fully written rows ever reach the window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Randomized bench for conv3x3_engine against a direct image-convolution model.
module tb_conv3x3_engine;

  localparam int W = 5;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pixel_valid = 1'b0;
  logic [7:0] pixel_in = '0;
  logic signed [7:0] kin [9];
  logic busy, conv_valid, done;
  logic signed [19:0] conv_out;

  conv3x3_engine #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .kernel0(kin[0]), .kernel1(kin[1]), .kernel2(kin[2]),
    .kernel3(kin[3]), .kernel4(kin[4]), .kernel5(kin[5]),
    .kernel6(kin[6]), .kernel7(kin[7]), .kernel8(kin[8]),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .busy(busy), .conv_out(conv_out),
    .conv_valid(conv_valid), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int img [W*H];
  int kern [9];
  int exp_v [$];
  int exp_c [$];
  bit exp_l [$];
  int done_cnt = 0;
  int frames = 0;
  int last_out = 0;
  bit prev_done = 1'b0;

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", nm, got, want, cyc);
    end
  endtask

  function automatic int model(int r, int c);
    int s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += img[(r-2+dr)*W + (c-2+dc)] * kern[dr*3+dc];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", conv_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_out", conv_out, 0);
      last_out = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", busy, 0);
      if (conv_valid) begin
        if (exp_v.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          int v, c;
          bit l;
          v = exp_v.pop_front();
          c = exp_c.pop_front();
          l = exp_l.pop_front();
          chk("conv_out", conv_out, v);
          chk("latency", cyc, c);
          chk("done_at_last", done, l);
          if (l) chk("busy_at_done", busy, 1);
        end
        last_out = conv_out;
      end else begin
        chk("done_no_valid", done, 0);
        chk("hold_out", conv_out, last_out);
      end
      if (done) done_cnt++;
      prev_done = done;
    end
  end

  task automatic run_frame(int kind, bit bub, int stop_after);
    int t;
    bit v;
    for (int i = 0; i < 9; i++)
      case (kind)
        0: kern[i] = 1;
        1: kern[i] = (i == 4) ? 1 : 0;
        2: kern[i] = -1;
        default: kern[i] = int'($urandom_range(0, 255)) - 128;
      endcase
    for (int i = 0; i < W*H; i++)
      case (kind)
        0: img[i] = 1;
        1: img[i] = i;
        2: img[i] = 255;
        default: img[i] = int'($urandom_range(0, 255));
      endcase
    if (kind == 0) chk("model_ones", model(2, 2), 9);
    if (kind == 2) chk("model_neg", model(3, 3), -2295);
    if (kind == 1) begin
      int want [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
      int k = 0;
      for (int r = 2; r < H; r++)
        for (int c = 2; c < W; c++) begin
          chk("model_ramp", model(r, c), want[k]);
          k++;
        end
    end
    for (int i = 0; i < 9; i++) kin[i] = 8'(kern[i]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < stop_after; i++) begin
      do begin
        v = bub ? 1'($urandom_range(0, 1)) : 1'b1;
        pixel_valid = v;
        pixel_in = v ? 8'(img[i]) : 8'($urandom);
        if (bub) begin
          for (int j = 0; j < 9; j++) kin[j] = 8'($urandom);
          start = ($urandom_range(0, 5) == 0);
        end
        if (v && (i / W) >= 2 && (i % W) >= 2) begin
          exp_v.push_back(model(i / W, i % W));
          exp_c.push_back(cyc + 2);
          exp_l.push_back(i == W*H - 1);
        end
        @(posedge clk); #1;
      end while (!v);
    end
    pixel_valid = 1'b0;
    start = 1'b0;
    if (stop_after < W*H) return;
    frames++;
    t = 0;
    while (busy && t < 12) begin
      start = 1'b1;
      pixel_valid = 1'b1;
      pixel_in = 8'($urandom);
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk("frame_end_timeout", busy, 0);
    repeat (4) begin
      pixel_valid = 1'b1;
      pixel_in = 8'($urandom);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) kin[i] = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    run_frame(0, 1'b0, W*H);
    run_frame(1, 1'b0, W*H);
    run_frame(2, 1'b0, W*H);
    run_frame(1, 1'b1, W*H);
    run_frame(1, 1'b0, 12);
    rst = 1'b0;
    exp_v.delete();
    exp_c.delete();
    exp_l.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    run_frame(1, 1'b0, W*H);
    repeat (6) run_frame(3, 1'($urandom_range(0, 1)), W*H);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pending_outputs", exp_v.size(), 0);
    chk("done_count", done_cnt, frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
